// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns MAC byte frames into GMII bytes (1000M) or MII nibbles (10/100M) with preamble/SFD, IFG and error signalling.
// Latency: the first preamble unit is registered on the first slot with s_tvalid; every output moves only on gmii_clk_en slots.
// Backpressure: s_tready is combinational, high on payload slots that need a new byte, and always high while draining an underflowed frame.
// Ports: clk/rst (sync, active high); s_t* byte stream in; gmii_clk_en slot strobe; speed (00=10M, 01=100M, 1x=1000M);
//        ifg_delay in byte times; gmii_txd/gmii_tx_en/gmii_tx_er to the PHY interface; start_packet and error_underflow pulses.
module gmii_tx_framer #(
    parameter int MIN_IFG        = 12,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    input  logic       s_tuser,
    input  logic       gmii_clk_en,
    input  logic [1:0] speed,
    input  logic [7:0] ifg_delay,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DRAIN, IFG} state_t;

    // Index of the SFD unit: after PREAMBLE_BYTES bytes in GMII; in MII the SFD low nibble is
    // another 0x5, so only the final nibble (0xD) differs.
    localparam logic [5:0] PRE_LAST_GMII = 6'(PREAMBLE_BYTES);
    localparam logic [5:0] PRE_LAST_MII  = 6'(2 * PREAMBLE_BYTES + 1);

    state_t     state_q, state_d;
    logic       mii_q, mii_d;
    logic [5:0] cnt_q, cnt_d;
    logic       nib_q, nib_d;
    logic [3:0] hold_q, hold_d;
    logic       hold_er_q, hold_er_d;
    logic       hold_last_q, hold_last_d;
    logic [8:0] ifg_q, ifg_d;
    logic [7:0] txd_q, txd_d;
    logic       en_q, en_d;
    logic       er_q, er_d;
    logic       sp_q, sp_d;
    logic       uf_q, uf_d;

    logic       mii_now;
    logic       last_unit;
    logic       bad;
    logic [7:0] eff_ifg;
    logic [8:0] ifg_load;

    // Both speed codes below 1000M select nibble mode.
    assign mii_now   = (speed == 2'b00) || (speed == 2'b01);
    assign last_unit = mii_q ? (cnt_q == PRE_LAST_MII) : (cnt_q == PRE_LAST_GMII);
    assign bad       = s_tlast & s_tuser;
    assign eff_ifg   = (ifg_delay < 8'(MIN_IFG)) ? 8'(MIN_IFG) : ifg_delay;
    // MII spends two slots per byte time.
    assign ifg_load  = mii_q ? {eff_ifg, 1'b0} : {1'b0, eff_ifg};

    always_comb begin
        s_tready = 1'b0;
        if (!rst) begin
            if (state_q == DRAIN)
                s_tready = 1'b1;
            else if (state_q == PAYLOAD)
                s_tready = gmii_clk_en && (!mii_q || !nib_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        mii_d       = mii_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        hold_d      = hold_q;
        hold_er_d   = hold_er_q;
        hold_last_d = hold_last_q;
        ifg_d       = ifg_q;
        txd_d       = txd_q;
        en_d        = en_q;
        er_d        = er_q;
        sp_d        = 1'b0;
        uf_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (gmii_clk_en) begin
                    txd_d = 8'h00;
                    en_d  = 1'b0;
                    er_d  = 1'b0;
                    if (s_tvalid) begin
                        mii_d   = mii_now;
                        txd_d   = mii_now ? 8'h05 : 8'h55;
                        en_d    = 1'b1;
                        sp_d    = 1'b1;
                        cnt_d   = 6'd1;
                        state_d = PREAMBLE;
                    end
                end
            end
            PREAMBLE: begin
                if (gmii_clk_en) begin
                    en_d  = 1'b1;
                    er_d  = 1'b0;
                    cnt_d = cnt_q + 6'd1;
                    if (last_unit) begin
                        txd_d   = mii_q ? 8'h0D : 8'hD5;
                        nib_d   = 1'b0;
                        state_d = PAYLOAD;
                    end else begin
                        txd_d = mii_q ? 8'h05 : 8'h55;
                    end
                end
            end
            PAYLOAD: begin
                if (gmii_clk_en) begin
                    if (mii_q && nib_q) begin
                        // Second nibble comes from the holding register; no upstream byte needed.
                        txd_d = {4'h0, hold_q};
                        en_d  = 1'b1;
                        er_d  = hold_er_q;
                        nib_d = 1'b0;
                        if (hold_last_q) begin
                            ifg_d   = ifg_load;
                            state_d = IFG;
                        end
                    end else if (s_tvalid) begin
                        en_d = 1'b1;
                        er_d = bad;
                        if (mii_q) begin
                            txd_d       = {4'h0, s_tdata[3:0]};
                            hold_d      = s_tdata[7:4];
                            hold_er_d   = bad;
                            hold_last_d = s_tlast;
                            nib_d       = 1'b1;
                        end else begin
                            txd_d = s_tdata;
                            if (s_tlast) begin
                                ifg_d   = ifg_load;
                                state_d = IFG;
                            end
                        end
                    end else begin
                        // Underflow only arises when a fresh byte is needed, so the
                        // frame's tlast is still owed and upstream must be drained.
                        txd_d   = 8'h00;
                        en_d    = 1'b1;
                        er_d    = 1'b1;
                        uf_d    = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (gmii_clk_en) begin
                    txd_d = 8'h00;
                    en_d  = 1'b0;
                    er_d  = 1'b0;
                end
                if (s_tvalid && s_tlast) begin
                    ifg_d   = ifg_load;
                    state_d = IFG;
                end
            end
            IFG: begin
                if (gmii_clk_en) begin
                    txd_d = 8'h00;
                    en_d  = 1'b0;
                    er_d  = 1'b0;
                    if (ifg_q <= 9'd1) begin
                        ifg_d   = 9'd0;
                        state_d = IDLE;
                    end else begin
                        ifg_d = ifg_q - 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mii_q       <= 1'b0;
            cnt_q       <= 6'd0;
            nib_q       <= 1'b0;
            hold_q      <= 4'h0;
            hold_er_q   <= 1'b0;
            hold_last_q <= 1'b0;
            ifg_q       <= 9'd0;
            txd_q       <= 8'h00;
            en_q        <= 1'b0;
            er_q        <= 1'b0;
            sp_q        <= 1'b0;
            uf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mii_q       <= mii_d;
            cnt_q       <= cnt_d;
            nib_q       <= nib_d;
            hold_q      <= hold_d;
            hold_er_q   <= hold_er_d;
            hold_last_q <= hold_last_d;
            ifg_q       <= ifg_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            er_q        <= er_d;
            sp_q        <= sp_d;
            uf_q        <= uf_d;
        end
    end

    assign gmii_txd        = txd_q;
    assign gmii_tx_en      = en_q;
    assign gmii_tx_er      = er_q;
    assign start_packet    = sp_q;
    assign error_underflow = uf_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: byte source from a queue, per-slot capture of {tx_er, txd} while tx_en is high,
// tx_en-low slot runs between frames, and hold/pulse rules between slots; all expectations are hand-written.
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic       s_tlast = 1'b0;
    logic       s_tuser = 1'b0;
    logic       gmii_clk_en = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [7:0] ifg_delay = 8'd12;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       start_packet;
    logic       error_underflow;

    gmii_tx_framer dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .gmii_clk_en(gmii_clk_en), .speed(speed), .ifg_delay(ifg_delay),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .start_packet(start_packet), .error_underflow(error_underflow)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] q_dat[$];
    logic       q_last[$];
    logic       q_user[$];
    int src_i = 0, gap_at = -1, gap_cnt = 0, div = 1, div_cnt = 0;
    int cyc = 0, first_sp = -1, hold_viol = 0, sp_viol = 0, uf_cnt = 0, run_len = 0;
    bit seen = 1'b0;
    logic [8:0] cap[$];
    logic [8:0] expq[$];
    int runs[$];
    logic [7:0] p_txd = 8'h00;
    logic       p_en = 1'b0, p_er = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_byte(input logic [7:0] d, input logic last, input logic user);
        q_dat.push_back(d);
        q_last.push_back(last);
        q_user.push_back(user);
    endtask

    task automatic drive_src();
        if (src_i < q_dat.size() && !(src_i == gap_at && gap_cnt > 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = q_dat[src_i];
            s_tlast  = q_last[src_i];
            s_tuser  = q_user[src_i];
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = 8'h00;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
            if (src_i == gap_at && gap_cnt > 0) gap_cnt--;
        end
    endtask

    // One clock: note the handshake and slot ahead of the edge, sample #1 after it, then drive the next inputs.
    task automatic step();
        bit hs, slot;
        #1;
        hs   = s_tvalid && s_tready;
        slot = gmii_clk_en;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) src_i++;
        div_cnt     = (div_cnt + 1) % div;
        gmii_clk_en = (div_cnt == 0);
        drive_src();
        if (!slot && {gmii_txd, gmii_tx_en, gmii_tx_er} !== {p_txd, p_en, p_er}) hold_viol++;
        if (start_packet !== (gmii_tx_en & ~p_en)) sp_viol++;
        if (start_packet === 1'b1 && first_sp < 0) first_sp = cyc;
        if (error_underflow === 1'b1) uf_cnt++;
        if (slot) begin
            if (gmii_tx_en) begin
                cap.push_back({gmii_tx_er, gmii_txd});
                if (run_len > 0) runs.push_back(run_len);
                run_len = 0;
                seen = 1'b1;
            end else if (seen) begin
                run_len++;
            end
        end
        p_txd = gmii_txd;
        p_en  = gmii_tx_en;
        p_er  = gmii_tx_er;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_dat.delete(); q_last.delete(); q_user.delete();
        src_i = 0; gap_at = -1; gap_cnt = 0; div = 1;
        step();
        step();
    endtask

    task automatic release_rst();
        cap.delete(); expq.delete(); runs.delete();
        run_len = 0; seen = 1'b0; hold_viol = 0; sp_viol = 0; uf_cnt = 0;
        first_sp = -1; cyc = 0;
        p_txd = 8'h00; p_en = 1'b0; p_er = 1'b0;
        div_cnt = 0;
        gmii_clk_en = 1'b1;
        drive_src();
        rst = 1'b0;
    endtask

    task automatic exp_pre(input bit mii);
        for (int i = 0; i < (mii ? 15 : 7); i++) expq.push_back(mii ? 9'h005 : 9'h055);
        expq.push_back(mii ? 9'h00D : 9'h0D5);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, cap.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < cap.size()) ? int'(cap[i]) : -1, int'(expq[i]));
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset_outputs", int'({gmii_txd, gmii_tx_en, gmii_tx_er, start_packet, error_underflow, s_tready}), 0);

        // 1000M basic frame
        speed = 2'b10; ifg_delay = 8'd12;
        add_byte(8'h11, 0, 0); add_byte(8'h22, 0, 0); add_byte(8'h33, 1, 0);
        release_rst();
        run(40);
        exp_pre(0);
        expq.push_back(9'h011); expq.push_back(9'h022); expq.push_back(9'h033);
        check_stream("g_basic");
        chk("g_basic_first_sp_cycle", first_sp, 1);
        chk("g_basic_sp_rule", sp_viol, 0);
        chk("g_basic_uf", uf_cnt, 0);

        // 100M, one slot in five
        do_reset();
        speed = 2'b01; div = 5;
        add_byte(8'hA5, 0, 0); add_byte(8'h3C, 1, 0);
        release_rst();
        run(130);
        for (int i = 0; i < 15; i++) expq.push_back(9'h005);
        expq.push_back(9'h00D);
        expq.push_back(9'h005); expq.push_back(9'h00A); expq.push_back(9'h00C); expq.push_back(9'h003);
        check_stream("m100");
        chk("m100_hold_between_slots", hold_viol, 0);
        chk("m100_sp_rule", sp_viol, 0);

        // 1000M underflow after 2nd byte, drain of 3 bytes, then a follow-on frame
        do_reset();
        speed = 2'b10; ifg_delay = 8'd12;
        add_byte(8'h11, 0, 0); add_byte(8'h22, 0, 0); add_byte(8'h33, 0, 0);
        add_byte(8'h44, 0, 0); add_byte(8'h55, 1, 0); add_byte(8'h66, 1, 0);
        gap_at = 2; gap_cnt = 1;
        release_rst();
        run(60);
        exp_pre(0);
        expq.push_back(9'h011); expq.push_back(9'h022); expq.push_back(9'h100);
        exp_pre(0);
        expq.push_back(9'h066);
        check_stream("uflow");
        chk("uflow_pulses", uf_cnt, 1);
        chk("uflow_consumed", src_i, 6);
        chk("uflow_runs_n", runs.size(), 1);
        chk("uflow_gap_drain3_ifg12", (runs.size() > 0) ? runs[0] : -1, 15);

        // Bad frame (tuser on last) at 1000M
        do_reset();
        speed = 2'b10;
        add_byte(8'h77, 0, 0); add_byte(8'h88, 1, 1);
        release_rst();
        run(30);
        exp_pre(0);
        expq.push_back(9'h077); expq.push_back(9'h188);
        check_stream("g_bad");

        // Bad frame in MII (10M code), both nibbles flagged
        do_reset();
        speed = 2'b00;
        add_byte(8'h9B, 1, 1);
        release_rst();
        run(40);
        exp_pre(1);
        expq.push_back(9'h10B); expq.push_back(9'h109);
        check_stream("m_bad");

        // Back-to-back, ifg_delay below minimum
        do_reset();
        speed = 2'b10; ifg_delay = 8'd4;
        add_byte(8'h01, 1, 0); add_byte(8'h02, 1, 0);
        release_rst();
        run(50);
        chk("ifg4_runs_n", runs.size(), 1);
        chk("ifg4_gap", (runs.size() > 0) ? runs[0] : -1, 12);

        // Back-to-back, ifg_delay=20 at 1000M
        do_reset();
        speed = 2'b10; ifg_delay = 8'd20;
        add_byte(8'h03, 1, 0); add_byte(8'h04, 1, 0);
        release_rst();
        run(60);
        chk("ifg20_g_gap", (runs.size() > 0) ? runs[0] : -1, 20);

        // Back-to-back, ifg_delay=20 in MII
        do_reset();
        speed = 2'b01; ifg_delay = 8'd20;
        add_byte(8'h05, 1, 0); add_byte(8'h06, 1, 0);
        release_rst();
        run(100);
        chk("ifg20_m_gap", (runs.size() > 0) ? runs[0] : -1, 40);

        // Reset in the middle of the payload with tvalid held
        do_reset();
        speed = 2'b10; ifg_delay = 8'd12;
        for (int i = 0; i < 10; i++) add_byte(8'(8'hC0 + i), (i == 9), 0);
        release_rst();
        run(10);
        chk("midrst_payload_byte1", int'(gmii_txd), 'hC1);
        rst = 1'b1;
        step();
        chk("midrst_outputs_zero", int'({gmii_txd, gmii_tx_en, gmii_tx_er, start_packet, error_underflow, s_tready}), 0);
        rst = 1'b0;
        step();
        chk("midrst_restart_en", int'(gmii_tx_en), 1);
        chk("midrst_restart_txd", int'(gmii_txd), 'h55);
        chk("midrst_restart_sp", int'(start_packet), 1);
        chk("midrst_not_drained", src_i, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
